// File: rtl/noise_pkg.sv
// ============================================================================
// Module  : noise_pkg
// Brief   : Shared state encoding, pixel type and impulse-noise rule.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package noise_pkg;

   localparam int c_pixel_width = 8;

   typedef logic [c_pixel_width-1:0] pixel_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_DONE   = 2'd3
   } ctrl_state_t;

   // Kept width-agnostic so blocks with other pixel widths can reuse it.
   function automatic logic noise_rule(input logic at_min, input logic at_max,
                                       input logic flat);
      return (at_min || at_max) && !flat;
   endfunction

endpackage

`default_nettype wire

// File: rtl/median_line_buffer.sv
// ============================================================================
// Module  : median_line_buffer
// Brief   : IMG_WIDTH-deep shift delay line; advances only when enabled.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module median_line_buffer #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] r_mem [0:IMG_WIDTH-1];

   always_ff @(posedge clk) begin
      if (en) begin
         r_mem[0] <= din;
         for (int i = 1; i < IMG_WIDTH; i++) begin
            r_mem[i] <= r_mem[i-1];
         end
      end
   end

   assign dout = r_mem[IMG_WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/sorter9.sv
// ============================================================================
// Module  : sorter9
// Brief   : Combinational 9-input network returning min, median and max.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sorter9 #(
   parameter int DATA_WIDTH = 8
) (
   input  logic [8:0][DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0]      vmin,
   output logic [DATA_WIDTH-1:0]      vmed,
   output logic [DATA_WIDTH-1:0]      vmax
);

   logic [DATA_WIDTH-1:0] w_s [0:8];
   logic [DATA_WIDTH-1:0] w_tmp;

   always_comb begin
      w_tmp = '0;
      for (int i = 0; i < 9; i++) begin
         w_s[i] = din[i];
      end
      for (int p = 0; p < 8; p++) begin
         for (int j = 0; j < 8 - p; j++) begin
            if (w_s[j] > w_s[j+1]) begin
               w_tmp    = w_s[j];
               w_s[j]   = w_s[j+1];
               w_s[j+1] = w_tmp;
            end
         end
      end
   end

   assign vmin = w_s[0];
   assign vmed = w_s[4];
   assign vmax = w_s[8];

endmodule

`default_nettype wire

// File: rtl/median_window_ctrl.sv
// ============================================================================
// Module  : median_window_ctrl
// Brief   : Streams a raster frame through a 3x3 window, emitting median or
//           original pixel for each interior position plus a noise flag.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module median_window_ctrl
   import noise_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 16,
   parameter int IMG_HEIGHT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_pixel,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_pixel,
   output logic                  out_noise,
   output logic                  busy,
   output logic                  done
);

   localparam int c_cw = $clog2(IMG_WIDTH);
   localparam int c_rw = $clog2(IMG_HEIGHT);
   localparam logic [c_cw-1:0] c_col_last = c_cw'(IMG_WIDTH - 1);
   localparam logic [c_rw-1:0] c_row_last = c_rw'(IMG_HEIGHT - 1);
   localparam logic [c_cw-1:0] c_col_two  = c_cw'(2);
   localparam logic [c_rw-1:0] c_row_two  = c_rw'(2);

   ctrl_state_t           r_state;
   logic [c_cw-1:0]       r_col;
   logic [c_rw-1:0]       r_row;
   logic [DATA_WIDTH-1:0] r_wt [0:1];
   logic [DATA_WIDTH-1:0] r_wm [0:1];
   logic [DATA_WIDTH-1:0] r_wb [0:1];

   logic [DATA_WIDTH-1:0] w_lb1, w_lb2;
   logic [DATA_WIDTH-1:0] w_min, w_med, w_max;
   logic [8:0][DATA_WIDTH-1:0] w_win;
   logic                  w_accept, w_produce, w_last, w_noise;

   assign in_ready  = (r_state == ST_STREAM) && (!out_valid || out_ready);
   assign w_accept  = in_valid && in_ready;
   assign w_produce = w_accept && (r_row >= c_row_two) && (r_col >= c_col_two);
   assign w_last    = (r_row == c_row_last) && (r_col == c_col_last);

   median_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .IMG_WIDTH(IMG_WIDTH)) u_lb1 (
      .clk (clk),
      .en  (w_accept),
      .din (in_pixel),
      .dout(w_lb1)
   );

   median_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .IMG_WIDTH(IMG_WIDTH)) u_lb2 (
      .clk (clk),
      .en  (w_accept),
      .din (w_lb1),
      .dout(w_lb2)
   );

   // Newest column comes straight from the inputs so the result can be
   // registered on the same edge that accepts the completing pixel.
   assign w_win = {in_pixel, r_wb[1], r_wb[0],
                   w_lb1,    r_wm[1], r_wm[0],
                   w_lb2,    r_wt[1], r_wt[0]};

   sorter9 #(.DATA_WIDTH(DATA_WIDTH)) u_sorter (
      .din (w_win),
      .vmin(w_min),
      .vmed(w_med),
      .vmax(w_max)
   );

   assign w_noise = noise_rule(r_wm[1] == w_min, r_wm[1] == w_max, w_min == w_max);

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_wt[0] <= r_wt[1];
         r_wt[1] <= w_lb2;
         r_wm[0] <= r_wm[1];
         r_wm[1] <= w_lb1;
         r_wb[0] <= r_wb[1];
         r_wb[1] <= in_pixel;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_col     <= '0;
         r_row     <= '0;
         out_valid <= 1'b0;
         out_pixel <= '0;
         out_noise <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;

         if (w_produce) begin
            out_valid <= 1'b1;
            out_pixel <= w_noise ? w_med : r_wm[1];
            out_noise <= w_noise;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state <= ST_STREAM;
                  r_col   <= '0;
                  r_row   <= '0;
                  busy    <= 1'b1;
               end
            end
            ST_STREAM: begin
               if (w_accept) begin
                  if (r_col == c_col_last) begin
                     r_col <= '0;
                     r_row <= r_row + c_rw'(1);
                  end else begin
                     r_col <= r_col + c_cw'(1);
                  end
                  if (w_last) begin
                     r_state <= ST_FLUSH;
                  end
               end
            end
            ST_FLUSH: begin
               if (!out_valid || out_ready) begin
                  r_state <= ST_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
